// File: rtl/snes_con_reader.sv
// SNES-style controller poller: drives latch/clock, shifts in 16 serial bits, publishes the button word per frame.
// Optional build macro CON_DEBOUNCE_EN: a bit changes only after two consecutive agreeing frames.
module snes_con_reader #(
    parameter int unsigned POLL_DIV    = 833333,
    parameter int unsigned HALF_PERIOD = 300,
    parameter int unsigned NUM_BITS    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                con_data,
    output logic                con_clk,
    output logic                con_latch,
    output logic [NUM_BITS-1:0] con_state,
    output logic                state_valid,
    output logic                busy
);

    localparam int unsigned PC_W  = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int unsigned HC_W  = $clog2(2 * HALF_PERIOD);
    localparam int unsigned IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

    localparam logic [PC_W-1:0]  POLL_LAST  = PC_W'(POLL_DIV - 1);
    localparam logic [HC_W-1:0]  LATCH_LAST = HC_W'(2 * HALF_PERIOD - 1);
    localparam logic [HC_W-1:0]  HALF_LAST  = HC_W'(HALF_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_WAIT_HI,
        ST_CLK_LO,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [HC_W-1:0]     hc_q, hc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_BITS-1:0] shift_q, shift_d;
    logic [NUM_BITS-1:0] con_state_q, con_state_d;
    logic [1:0]          sync_q;
    logic                con_clk_q, con_clk_d;
    logic                con_latch_q, con_latch_d;
    logic                state_valid_q, state_valid_d;
    logic                busy_q, busy_d;
    logic                tick_c;
    logic                publish_c;

`ifdef CON_DEBOUNCE_EN
    logic [NUM_BITS-1:0] prev_q, prev_d;
    logic [NUM_BITS-1:0] agree_c;
`endif

    // Two-flop synchronizer; the line idles high (no button pressed).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], con_data};
        end
    end

    // Free-running poll divider; a tick is the cycle where it reads zero.
    assign pc_d   = (pc_q == POLL_LAST) ? '0 : pc_q + 1'b1;
    assign tick_c = (pc_q == '0);

    // Frame sequencer: next-state, phase counter, bit index and shift register.
    always_comb begin
        state_d = state_q;
        hc_d    = hc_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;

        case (state_q)
            ST_IDLE: begin
                hc_d = '0;
                if (tick_c && en) begin
                    state_d = ST_LATCH;
                    idx_d   = '0;
                end
            end
            ST_LATCH: begin
                if (hc_q == LATCH_LAST) begin
                    state_d = ST_WAIT_HI;
                    hc_d    = '0;
                end
            end
            ST_WAIT_HI: begin
                if (hc_q == HALF_LAST) begin
                    hc_d           = '0;
                    shift_d[idx_q] = ~sync_q[1];
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_CLK_LO;
                    end
                end
            end
            ST_CLK_LO: begin
                if (hc_q == HALF_LAST) begin
                    state_d = ST_WAIT_HI;
                    hc_d    = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                hc_d    = '0;
            end
            default: begin
                state_d = ST_IDLE;
                hc_d    = '0;
            end
        endcase
    end

    // The word is committed on entry to DONE so it appears together with state_valid.
    assign publish_c = (state_q == ST_WAIT_HI) && (state_d == ST_DONE);

`ifdef CON_DEBOUNCE_EN
    assign agree_c = ~(shift_d ^ prev_q);

    always_comb begin
        con_state_d = con_state_q;
        prev_d      = prev_q;
        if (publish_c) begin
            con_state_d = (con_state_q & ~agree_c) | (shift_d & agree_c);
            prev_d      = shift_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end
`else
    always_comb begin
        con_state_d = con_state_q;
        if (publish_c) begin
            con_state_d = shift_d;
        end
    end
`endif

    // Pin and status values decoded from the upcoming state so every output is a flop.
    always_comb begin
        con_clk_d     = (state_d != ST_CLK_LO);
        con_latch_d   = (state_d == ST_LATCH);
        state_valid_d = (state_d == ST_DONE);
        busy_d        = (state_d == ST_LATCH) || (state_d == ST_WAIT_HI) ||
                        (state_d == ST_CLK_LO);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            hc_q          <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            con_state_q   <= '0;
            con_clk_q     <= 1'b1;
            con_latch_q   <= 1'b0;
            state_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            hc_q          <= hc_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            con_state_q   <= con_state_d;
            con_clk_q     <= con_clk_d;
            con_latch_q   <= con_latch_d;
            state_valid_q <= state_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign con_clk     = con_clk_q;
    assign con_latch   = con_latch_q;
    assign con_state   = con_state_q;
    assign state_valid = state_valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_snes_con_reader.sv
// Bench for snes_con_reader: controller pin model, frame-timing reference model and directed scenarios.
module tb_snes_con_reader;

    localparam int unsigned H         = 4;
    localparam int unsigned PD        = 200;
    localparam int unsigned NB        = 16;
    localparam int          FRAME_LEN = 33 * H + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          con_data;
    logic          con_clk;
    logic          con_latch;
    logic [NB-1:0] con_state;
    logic          state_valid;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    snes_con_reader #(
        .POLL_DIV    (PD),
        .HALF_PERIOD (H),
        .NUM_BITS    (NB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .con_data    (con_data),
        .con_clk     (con_clk),
        .con_latch   (con_latch),
        .con_state   (con_state),
        .state_valid (state_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Controller: latch loads button 0, each rising clock advances; pressed = low, then 1s.
    logic [NB-1:0] pat;
    int            ctl_idx = NB;

    always @(posedge con_clk or posedge con_latch) begin
        if (con_latch) ctl_idx = 0;
        else if (ctl_idx < NB) ctl_idx = ctl_idx + 1;
    end

    assign con_data = (ctl_idx < NB) ? ~pat[ctl_idx] : 1'b1;

    // Reference model: position within a frame measured in cycles from the accepted tick.
    int            m_pc;
    int            m_k;
    logic [NB-1:0] m_state;
    logic [NB-1:0] m_prev;
    logic [NB-1:0] m_pat;
    logic          model_ok = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc     = 0;
            m_k      = 0;
            m_state  = '0;
            m_prev   = '0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (m_pc == 0 && en && m_k == 0) begin
                m_k   = 1;
                m_pat = pat;
            end else if (m_k == FRAME_LEN) begin
                m_k = 0;
            end else if (m_k != 0) begin
                m_k = m_k + 1;
            end
            if (m_k == FRAME_LEN) begin
`ifdef CON_DEBOUNCE_EN
                for (int i = 0; i < NB; i++)
                    if (m_pat[i] == m_prev[i]) m_state[i] = m_pat[i];
                m_prev = m_pat;
`else
                m_state = m_pat;
`endif
            end
            m_pc = (m_pc == PD - 1) ? 0 : m_pc + 1;
        end
    end

    function automatic logic exp_clk(input int k);
        if (k >= 3 * H + 1 && k <= 33 * H && ((k - 3 * H - 1) % (2 * H)) < H) return 1'b0;
        return 1'b1;
    endfunction

    // Event counters plus the per-cycle comparison against the model.
    int   cyc_n            = 0;
    int   lat_total        = 0;
    int   clk_fall_total   = 0;
    int   valid_total      = 0;
    int   latch_rise_total = 0;
    int   valid_cyc        = 0;
    int   latch_rise_cyc   = 0;
    logic prev_clk         = 1'b1;
    logic prev_lat         = 1'b0;

    always @(negedge clk) begin
        cyc_n = cyc_n + 1;
        if (con_latch === 1'b1) lat_total = lat_total + 1;
        if (prev_clk === 1'b1 && con_clk === 1'b0) clk_fall_total = clk_fall_total + 1;
        if (con_latch === 1'b1 && prev_lat !== 1'b1) begin
            latch_rise_total = latch_rise_total + 1;
            latch_rise_cyc   = cyc_n;
        end
        if (state_valid === 1'b1) begin
            valid_total = valid_total + 1;
            valid_cyc   = cyc_n;
        end
        prev_clk = con_clk;
        prev_lat = con_latch;
        if (model_ok) begin
            chk("cyc_con_latch", 32'(con_latch), 32'(m_k >= 1 && m_k <= 2 * H));
            chk("cyc_con_clk", 32'(con_clk), 32'(exp_clk(m_k)));
            chk("cyc_busy", 32'(busy), 32'(m_k >= 1 && m_k <= 33 * H));
            chk("cyc_state_valid", 32'(state_valid), 32'(m_k == FRAME_LEN));
            chk("cyc_con_state", 32'(con_state), 32'(m_state));
        end
    end

    task automatic wait_valid(input int maxc, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (state_valid !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n = n + 1;
        end
        checks = checks + 1;
        if (state_valid !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL %s: state_valid not seen within %0d cycles", tag, maxc);
        end
        #1;
    endtask

    int v1, v2, s_lat, s_fall, s_val, s_rise, n;
    logic [NB-1:0] obs [4];

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        pat   = 16'h5A3C;
        repeat (3) @(negedge clk);
        chk("reset_con_clk", 32'(con_clk), 32'd1);
        chk("reset_con_latch", 32'(con_latch), 32'd0);
        chk("reset_con_state", 32'(con_state), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        s_lat  = lat_total;
        s_fall = clk_fall_total;
        rst_n  = 1'b1;

        // Test 1: timing of one frame carrying 0x5A3C.
        wait_valid(FRAME_LEN + 10, "t1_wait");
        chk("t1_latch_cycles", 32'(lat_total - s_lat), 32'd8);
        chk("t1_clk_low_pulses", 32'(clk_fall_total - s_fall), 32'd15);
        chk("t1_valid_offset", 32'(valid_cyc - latch_rise_cyc + 1), 32'd133);
`ifdef CON_DEBOUNCE_EN
        chk("t1_con_state", 32'(con_state), 32'h0000);
`else
        chk("t1_con_state", 32'(con_state), 32'h5A3C);
`endif

        // Test 2: released line, valid once per poll period, idle between frames.
        pat   = 16'h0000;
        s_val = valid_total;
        wait_valid(PD + 10, "t2_wait_a");
        v1 = valid_cyc;
        wait_valid(PD + 10, "t2_wait_b");
        v2 = valid_cyc;
        chk("t2_valid_period", 32'(v2 - v1), 32'd200);
        chk("t2_valid_count", 32'(valid_total - s_val), 32'd2);
        chk("t2_con_state", 32'(con_state), 32'h0000);
        repeat (5) @(negedge clk);
        chk("t2_busy_idle", 32'(busy), 32'd0);

        // Test 3: reset in the middle of a frame after publishing 0xFFFF.
        pat = 16'hFFFF;
        wait_valid(PD + 10, "t3_wait_a");
        wait_valid(PD + 10, "t3_wait_b");
        chk("t3_published", 32'(con_state), 32'hFFFF);
        s_fall = clk_fall_total;
        n = 0;
        while (clk_fall_total - s_fall < 7 && n < PD + 10) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("t3_reached_bit7", 32'(clk_fall_total - s_fall), 32'd7);
        #1;
        rst_n = 1'b0;
        s_val = valid_total;
        @(negedge clk);
        chk("t3_rst_con_clk", 32'(con_clk), 32'd1);
        chk("t3_rst_con_latch", 32'(con_latch), 32'd0);
        chk("t3_rst_con_state", 32'(con_state), 32'd0);
        chk("t3_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        chk("t3_no_valid", 32'(valid_total - s_val), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t3_restart_latch", 32'(con_latch), 32'd1);

        // Test 4: en dropped mid-frame, frame still completes; no frames while en low.
        s_fall = clk_fall_total;
        n = 0;
        while (clk_fall_total - s_fall < 3 && n < PD) begin
            @(negedge clk);
            n = n + 1;
        end
        #1;
        en = 1'b0;
        wait_valid(PD, "t4_complete");
`ifdef CON_DEBOUNCE_EN
        chk("t4_con_state", 32'(con_state), 32'h0000);
`else
        chk("t4_con_state", 32'(con_state), 32'hFFFF);
`endif
        s_rise = latch_rise_total;
        repeat (450) @(negedge clk);
        chk("t4_no_latch_when_off", 32'(latch_rise_total - s_rise), 32'd0);
        #1;
        en = 1'b1;
        n = 0;
        while (latch_rise_total == s_rise && n < PD + 10) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("t4_resume", 32'(latch_rise_total - s_rise), 32'd1);
        wait_valid(FRAME_LEN + 10, "t4_resume_done");

        // Tests 5/6: settle to zero, then frames 0x0001, 0x0001, 0x0000, 0x0000.
        pat = 16'h0000;
        wait_valid(PD + 10, "t5_clear_a");
        wait_valid(PD + 10, "t5_clear_b");
        chk("t5_cleared", 32'(con_state), 32'h0000);
        for (int f = 0; f < 4; f++) begin
            pat = (f < 2) ? 16'h0001 : 16'h0000;
            wait_valid(PD + 10, "t5_frame");
            obs[f] = con_state;
        end
`ifdef CON_DEBOUNCE_EN
        chk("t5_frame_a", 32'(obs[0]), 32'h0000);
        chk("t5_frame_b", 32'(obs[1]), 32'h0001);
        chk("t5_frame_c", 32'(obs[2]), 32'h0001);
        chk("t5_frame_d", 32'(obs[3]), 32'h0000);
`else
        chk("t6_frame_a", 32'(obs[0]), 32'h0001);
        chk("t6_frame_b", 32'(obs[1]), 32'h0001);
        chk("t6_frame_c", 32'(obs[2]), 32'h0000);
        chk("t6_frame_d", 32'(obs[3]), 32'h0000);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
